// File: rtl/rx_word_assembler.sv
// rx_word_assembler: packs received bytes MSB-first into words and writes
// one frame of WORD_COUNT words, dropping a partial word on an inter-byte timeout.
module rx_word_assembler #(
    parameter int BYTES_PER_WORD = 5,
    parameter int WORD_COUNT     = 768,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    output logic                        ram_write_en,
    output logic [ADDR_W-1:0]           ram_write_addr,
    output logic [8*BYTES_PER_WORD-1:0] ram_data_in,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err
);
    localparam int WW  = 8 * BYTES_PER_WORD;
    localparam int BIW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int GW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BIW-1:0]    LAST_BYTE = BIW'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORD_COUNT - 1);
    localparam logic [GW-1:0]     GAP_MAX   = GW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t            r_state;
    logic [BIW-1:0]    r_byte_idx;
    logic [ADDR_W-1:0] r_word_idx;
    logic [GW-1:0]     r_gap;
    logic [WW-1:0]     r_shift;
    logic [WW-1:0]     r_data;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic              r_terr;

    logic              w_timeout;
    logic              w_to_done;
    logic              w_take;
    logic              w_last;
    logic [BIW-1:0]    w_bidx;
    logic [WW-1:0]     w_word;

    // A timeout on the same cycle as a byte restarts the word at byte 0.
    assign w_timeout = (r_byte_idx != '0) && (r_gap == GAP_MAX);
    assign w_bidx    = w_timeout ? '0 : r_byte_idx;
    assign w_to_done = (r_state == WRITE) && (r_word_idx == LAST_WORD);
    assign w_take    = rx_valid && !w_to_done;
    assign w_last    = w_take && (w_bidx == LAST_BYTE);
    assign w_word    = WW'({r_shift, rx_data});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_gap      <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_terr     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (start) begin
                r_state    <= COLLECT;
                r_byte_idx <= '0;
                r_word_idx <= '0;
                r_gap      <= '0;
                r_shift    <= '0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_terr     <= 1'b0;
            end else if (r_state == COLLECT || r_state == WRITE) begin
                if (r_state == WRITE) begin
                    if (w_to_done) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_word_idx <= r_word_idx + 1'b1;
                        r_state    <= COLLECT;
                    end
                end
                if (w_timeout) begin
                    r_terr     <= 1'b1;
                    r_byte_idx <= '0;
                    r_gap      <= '0;
                end else if (r_byte_idx != '0) begin
                    r_gap <= r_gap + 1'b1;
                end
                if (w_take) begin
                    r_gap   <= '0;
                    r_shift <= w_word;
                    if (w_last) begin
                        r_data     <= w_word;
                        r_byte_idx <= '0;
                        r_state    <= WRITE;
                        r_wr_en    <= 1'b1;
                    end else begin
                        r_byte_idx <= w_bidx + 1'b1;
                    end
                end
            end
        end
    end

    assign ram_write_en   = r_wr_en;
    assign ram_write_addr = r_word_idx;
    assign ram_data_in    = r_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign timeout_err    = r_terr;

endmodule

// File: tb/tb_rx_word_assembler.sv
// tb_rx_word_assembler: vector table, directed corner sequences and random
// traffic against a queue-based reference model of the word assembler.
module tb_rx_word_assembler;
    localparam int BPW = 5;
    localparam int WC  = 4;
    localparam int AW  = 10;
    localparam int TO  = 16;
    localparam int WW  = 8 * BPW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          ram_write_en;
    logic [AW-1:0] ram_write_addr;
    logic [WW-1:0] ram_data_in;
    logic          busy;
    logic          done;
    logic          timeout_err;

    always #5 clk = ~clk;

    rx_word_assembler #(
        .BYTES_PER_WORD(BPW),
        .WORD_COUNT(WC),
        .ADDR_W(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .ram_write_en(ram_write_en),
        .ram_write_addr(ram_write_addr),
        .ram_data_in(ram_data_in),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes of the current word in a queue, idle gap
    // measured from the cycle stamp of the last accepted byte.
    logic          m_armed, m_done, m_terr, m_pend, m_fin;
    logic [AW-1:0] m_words;
    logic [WW-1:0] m_data;
    logic [7:0]    m_q[$];
    int            m_cyc = 0;
    int            m_last = 0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_armed = 0; m_done = 0; m_terr = 0; m_pend = 0;
                m_words = '0; m_data = '0; m_q.delete();
            end else begin
                m_cyc++;
                if (start) begin
                    m_armed = 1; m_done = 0; m_terr = 0; m_pend = 0;
                    m_words = '0; m_q.delete();
                end else if (m_armed) begin
                    m_fin = m_pend && (m_words == AW'(WC - 1));
                    if (m_pend) begin
                        if (m_fin) begin
                            m_armed = 0;
                            m_done  = 1;
                        end else begin
                            m_words++;
                        end
                    end
                    m_pend = 0;
                    if (m_q.size() > 0 && (m_cyc - m_last - 1) == TO) begin
                        m_q.delete();
                        m_terr = 1;
                    end
                    if (rx_valid && !m_fin) begin
                        m_q.push_back(rx_data);
                        m_last = m_cyc;
                        if (m_q.size() == BPW) begin
                            m_data = '0;
                            foreach (m_q[i])
                                m_data = m_data | (WW'(m_q[i]) << (8 * (BPW - 1 - i)));
                            m_pend = 1;
                            m_q.delete();
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("mdl_wr_en", ram_write_en, m_pend);
            chk("mdl_addr", ram_write_addr, m_words);
            chk("mdl_data", ram_data_in, m_data);
            chk("mdl_busy", busy, m_armed);
            chk("mdl_done", done, m_done);
            chk("mdl_terr", timeout_err, m_terr);
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [WW-1:0] d;
    } wr_t;
    wr_t wq[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ram_write_en === 1'b1)
                wq.push_back('{ram_write_addr, ram_data_in});
        end
    end

    typedef struct {
        logic          st;
        logic          v;
        logic [7:0]    d;
        logic          e_wr;
        logic [AW-1:0] e_a;
        logic [WW-1:0] e_d;
        logic          e_busy;
        logic          e_done;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic st, input logic v, input logic [7:0] d,
                       input logic e_wr, input logic [AW-1:0] e_a,
                       input logic [WW-1:0] e_d, input logic e_busy,
                       input logic e_done);
        tbl.push_back('{st, v, d, e_wr, e_a, e_d, e_busy, e_done});
    endtask

    task automatic drv(input logic st, input logic v, input logic [7:0] d);
        @(negedge clk);
        start = st;
        rx_valid = v;
        rx_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_writes(input string nm, input int n, input logic [WW-1:0] ed[4]);
        chk({nm, "_nwr"}, wq.size(), n);
        for (int i = 0; i < n && i < wq.size(); i++) begin
            chk({nm, "_addr"}, wq[i].a, i);
            chk({nm, "_data"}, wq[i].d, ed[i]);
        end
    endtask

    initial begin
        logic [7:0]    b5[5];
        logic [WW-1:0] ew[4];
        int            p;

        reset_n = 0; start = 0; rx_valid = 0; rx_data = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", ram_write_en, 0);
        chk("rst_addr", ram_write_addr, 0);
        chk("rst_data", ram_data_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_terr", timeout_err, 0);
        @(negedge clk);
        reset_n = 1;

        // Single word with 3-cycle gaps, one row per clock.
        b5 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        add(1, 0, 8'h00, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            add(0, 1, b5[i], i == 4, 0, (i == 4) ? 40'h123456789A : 40'h0, 1, 0);
            if (i < 4) repeat (3) add(0, 0, 8'h00, 0, 0, 0, 1, 0);
        end
        add(0, 0, 8'h00, 0, 1, 40'h123456789A, 1, 0);
        add(0, 0, 8'h00, 0, 1, 40'h123456789A, 1, 0);
        foreach (tbl[i]) begin
            @(negedge clk);
            start = tbl[i].st;
            rx_valid = tbl[i].v;
            rx_data = tbl[i].d;
            @(posedge clk);
            #1;
            chk("tbl_wr_en", ram_write_en, tbl[i].e_wr);
            chk("tbl_addr", ram_write_addr, tbl[i].e_a);
            chk("tbl_data", ram_data_in, tbl[i].e_d);
            chk("tbl_busy", busy, tbl[i].e_busy);
            chk("tbl_done", done, tbl[i].e_done);
        end
        idle(1);

        // Full frame of back-to-back bytes, then surplus bytes.
        wq.delete();
        drv(1, 0, 8'h00);
        for (int i = 0; i < 20; i++) drv(0, 1, 8'(i));
        repeat (3) drv(0, 1, 8'hEE);
        idle(3);
        ew = '{40'h0001020304, 40'h0506070809, 40'h0A0B0C0D0E, 40'h0F10111213};
        chk_writes("frame", 4, ew);
        chk("frame_done", done, 1);
        chk("frame_busy", busy, 0);

        // Gap of TO-1 idle cycles keeps the word.
        wq.delete();
        drv(1, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            drv(0, 1, 8'hC0 + 8'(i));
            if (i < 4) idle(TO - 1);
        end
        idle(3);
        ew = '{40'hC0C1C2C3C4, 40'h0, 40'h0, 40'h0};
        chk_writes("gap15", 1, ew);
        chk("gap15_terr", timeout_err, 0);

        // Gap of TO idle cycles drops the partial word.
        wq.delete();
        drv(1, 0, 8'h00);
        drv(0, 1, 8'hAA);
        drv(0, 1, 8'hBB);
        idle(TO);
        for (int i = 1; i <= 5; i++) drv(0, 1, 8'(i));
        idle(3);
        ew = '{40'h0102030405, 40'h0, 40'h0, 40'h0};
        chk_writes("tmo", 1, ew);
        chk("tmo_terr", timeout_err, 1);

        // Abort mid-word; restart coincides with a discarded byte.
        wq.delete();
        drv(1, 0, 8'h00);
        drv(0, 1, 8'hA1);
        drv(0, 1, 8'hA2);
        drv(0, 1, 8'hA3);
        drv(1, 1, 8'h77);
        for (int i = 0; i < 5; i++) drv(0, 1, 8'hF0 + 8'(i));
        idle(3);
        ew = '{40'hF0F1F2F3F4, 40'h0, 40'h0, 40'h0};
        chk_writes("abort", 1, ew);
        chk("abort_terr", timeout_err, 0);

        // Reset while the write strobe is high.
        drv(1, 0, 8'h00);
        for (int i = 0; i < 5; i++) drv(0, 1, 8'h11 + 8'(i));
        @(negedge clk);
        chk("mw_pre_wr", ram_write_en, 1);
        start = 0; rx_valid = 0;
        reset_n = 0;
        #1;
        chk("mw_rst_wr", ram_write_en, 0);
        chk("mw_rst_data", ram_data_in, 0);
        chk("mw_rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1;

        // Reset on the cycle of the final byte.
        drv(1, 0, 8'h00);
        for (int i = 0; i < 4; i++) drv(0, 1, 8'h21 + 8'(i));
        @(negedge clk);
        rx_valid = 1;
        rx_data = 8'h55;
        reset_n = 0;
        #1;
        chk("lb_wr", ram_write_en, 0);
        chk("lb_addr", ram_write_addr, 0);
        chk("lb_busy", busy, 0);
        chk("lb_done", done, 0);
        chk("lb_terr", timeout_err, 0);
        @(posedge clk);
        #1;
        chk("lb_wr_edge", ram_write_en, 0);
        @(negedge clk);
        reset_n = 1;
        rx_valid = 0;
        wq.delete();
        for (int i = 0; i < 10; i++) drv(0, 1, 8'h60 + 8'(i));
        idle(3);
        chk("lb_nostart_nwr", wq.size(), 0);
        chk("lb_nostart_busy", busy, 0);

        // Random traffic; density changes so gaps sometimes time out.
        p = 50;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (c % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 90;
                    1: p = 40;
                    default: p = 7;
                endcase
            end
            if (reset_n == 1'b0)
                reset_n = 1;
            else if ($urandom_range(0, 1499) == 0)
                reset_n = 0;
            start = ($urandom_range(0, 149) == 0);
            rx_valid = (int'($urandom_range(0, 99)) < p);
            rx_data = 8'($urandom);
        end
        reset_n = 1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_word_assembler.md
RX_WORD_ASSEMBLER -- requirements
Module: rx_word_assembler

Interface
REQ-001 SHALL have parameter BYTES_PER_WORD, default 5, the number of bytes per assembled word.
REQ-002 SHALL have parameter WORD_COUNT, default 768, the number of words per frame.
REQ-003 SHALL have parameter ADDR_W, default 10, the RAM address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, the maximum allowed inter-byte gap within a word.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle pulse that arms frame capture.
REQ-008 SHALL have port rx_valid, input, 1 bit: a one-cycle strobe meaning rx_data holds a received byte.
REQ-009 SHALL have port rx_data, input, 8 bits: the received byte.
REQ-010 SHALL have port ram_write_en, output, 1 bit: the word write strobe.
REQ-011 SHALL have port ram_write_addr, output, ADDR_W bits: the word index.
REQ-012 SHALL have port ram_data_in, output, 8*BYTES_PER_WORD bits: the assembled word.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame is being captured.
REQ-014 SHALL have port done, output, 1 bit: high once all WORD_COUNT words are written.
REQ-015 SHALL have port timeout_err, output, 1 bit: sticky flag set when a partial word is dropped.

Function
REQ-016 SHALL implement exactly four states: IDLE, COLLECT, WRITE, DONE.
REQ-017 SHALL ignore rx_valid in IDLE and in DONE.
REQ-018 In IDLE or DONE, a start pulse SHALL do all of the following: clear the word index, byte index and timeout_err; drop done; enter COLLECT.
REQ-019 While in COLLECT or WRITE, busy SHALL be 1; otherwise busy SHALL be 0.
REQ-020 Bytes SHALL be assembled MSB-first: the first byte of a word lands in bits [8*BYTES_PER_WORD-1 -: 8], and the last byte lands in bits [7:0].
REQ-021 A byte SHALL be accepted on any cycle where rx_valid=1 in COLLECT or WRITE, including back-to-back cycles.
REQ-022 Acceptance of the final byte of a word SHALL do three things: copy the assembled word into the ram_data_in register; reset the byte index to 0; enter WRITE on the next cycle.
REQ-023 In WRITE, ram_write_en SHALL be 1 for exactly one cycle, with ram_write_addr equal to the current word index and ram_data_in stable.
REQ-024 Write latency SHALL be 1 cycle: if the last byte is accepted at edge N, ram_write_en is high during the cycle after edge N.
REQ-025 A byte arriving during WRITE SHALL be accepted as byte 0 of the next word, with no loss.
REQ-026 After a write to word index WORD_COUNT-1, the block SHALL enter DONE with done=1 and ram_write_en=0, and hold DONE until the next start.
REQ-027 After a write to any other word index, the word index SHALL increment by 1 and the block SHALL return to COLLECT.
REQ-028 The word index SHALL never wrap within a frame.
REQ-029 An inter-byte gap counter SHALL clear on every accepted byte and count only while the byte index is nonzero.
REQ-030 When the gap counter reaches TIMEOUT_CYCLES, the block SHALL discard the partial word, clear the byte index, set timeout_err=1, remain in COLLECT, and keep the word index unchanged.
REQ-031 If rx_valid coincides with the timeout cycle, the byte SHALL be taken as byte 0 of a fresh word.
REQ-032 timeout_err SHALL stay set until the next start or reset.
REQ-033 A start pulse during COLLECT or WRITE SHALL abort the frame: no write occurs that cycle, counters and partial data are cleared, and the block re-enters COLLECT.
REQ-034 If start and rx_valid occur in the same cycle, start SHALL win and the byte SHALL be discarded.
REQ-035 ram_write_en SHALL never be asserted outside WRITE.

Reset
REQ-036 reset_n=0 SHALL immediately, asynchronously, force: state IDLE; ram_write_en=0; ram_write_addr=0; ram_data_in=0; busy=0; done=0; timeout_err=0; and all internal counters and the shift register to 0.
REQ-037 Reset asserted mid-word or mid-write SHALL drop any pending write, with no glitch on ram_write_en.
REQ-038 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-039 Word scenario: start, then bytes 0x12,0x34,0x56,0x78,0x9A with gaps of 3 cycles -> one ram_write_en pulse the cycle after 0x9A, with addr=0, data=0x123456789A, busy=1.
REQ-040 Frame scenario (WORD_COUNT=4): 20 back-to-back bytes 0x00..0x13 -> 4 writes: addr 0..3, data 0x0001020304, 0x0506070809, 0x0A0B0C0D0E, 0x0F10111213; then done=1, busy=0; extra bytes cause no write.
REQ-041 Timeout scenario (TIMEOUT_CYCLES=16): bytes 0xAA,0xBB, then 16 idle cycles, then 0x01..0x05 -> timeout_err=1 and a single write with addr=0, data=0x0102030405.
REQ-042 Abort scenario: start, 3 bytes, start again, then 5 bytes 0xF0..0xF4 -> first write has addr=0, data=0xF0F1F2F3F4.
REQ-043 Reset scenario: reset_n=0 on the same cycle the last byte is accepted -> ram_write_en stays 0, all outputs read 0, and rx_valid is ignored until start.
